mult_share_sched: RTL and testbench
===================================

// Module: mult_share_sched
// PURPOSE
//  Shares one external shift-add multiplier datapath between NREQ requesters.
//  - Round-robin arbitration picks one requester at a time.
//  - Drives the datapath's load/add/shift controls with an internal bit counter.
//  - Signals completion to the granted requester with a one-cycle ack pulse.
//  - Sits between the requesting units and the multiplier datapath; replaces per-unit multiplier controllers.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  N     4  multiplier operand width in bits = number of shift steps (>=2)
// PORTS
//  clk        in   1              rising-edge clock, the only clock
//  rst_n      in   1              synchronous reset, active-low
//  req_i      in   NREQ           per-requester request; held high until ack_o bit pulses
//  M_i        in   1              current multiplier LSB from datapath
//  sel_o      out  $clog2(NREQ)   index of granted requester; datapath operand mux select
//  gnt_o      out  NREQ           one-hot grant; valid from LOAD through DONE, else 0
//  load_o     out  1              datapath load operands / clear accumulator
//  ad_o       out  1              datapath add multiplicand into accumulator
//  sh_o       out  1              datapath shift accumulator/multiplier right by 1
//  done_o     out  1              product valid in datapath this cycle
//  ack_o      out  NREQ           one-hot completion pulse to granted requester
//  busy_o     out  1              1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: rst_n sampled low at clk edge -> state IDLE, ptr=0, cnt=0, sel_o=0.
//    - All outputs 0 while in IDLE after reset. Reset mid-operation aborts it; no ack is issued.
//  - State register is the only sequential control. Outputs decode state combinationally; ad_o/sh_o in CALC also depend on M_i.
//  - IDLE: all controls 0.
//    - If |req_i: register the winner into sel_o/gnt_o, cnt<=0, go to LOAD.
//  - LOAD (1 cycle): load_o=1, go to CALC.
//  - CALC, M_i=1: ad_o=1, go to ADD; cnt unchanged.
//  - CALC, M_i=0: sh_o=1, cnt<=cnt+1. If cnt==N-1 go to DONE, else stay in CALC.
//  - ADD: sh_o=1, cnt<=cnt+1. If cnt==N-1 go to DONE, else go to CALC.
//  - DONE (1 cycle): done_o=1, ack_o=gnt_o, ptr<=(sel_o+1) mod NREQ, go to IDLE.
//  - load_o, ad_o and sh_o are mutually exclusive; never two high in one cycle.
//  - Arbitration: the winner is the first set bit of req_i searching from index ptr upward, wrapping at NREQ-1 -> 0.
//    - ptr changes only in DONE.
//  - Latency: req seen in IDLE at cycle t -> LOAD at t+1 -> DONE at t+2+N+k.
//    - k = number of 1 bits in the loaded multiplier.
//  - Back-to-back: DONE -> IDLE -> LOAD; one IDLE cycle between jobs is required.
//  - Requests are sampled only in IDLE. req_i changes during LOAD..DONE are ignored.
//    - A dropped req still completes and acks; a new req waits.
//  - cnt width is $clog2(N); it must never wrap within a job.
//  - M_i is ignored outside CALC.
// STRUCTURE
//  - Package mult_sched_pkg holds:
//    - state encoding localparams IDLE, LOAD, CALC, ADD, DONE (3-bit);
//    - the CNT_W/SEL_W width helper.
//  - Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot gnt and encoded idx.
//    - Purely combinational.
//  - Top holds: state FSM, bit counter, grant/sel registers, pointer register.
// TESTING
//  1. Reset, no req -> busy_o=0, all outputs 0 for 10 cycles.
//     - Then rst_n=0 for 1 cycle mid-CALC -> IDLE next cycle, no ack.
//  2. NREQ=4, N=4, req_i=0001, model mplier=1011 (M_i driven from model shift reg)
//     -> load_o at t+1, 3 ad_o pulses, 4 sh_o pulses.
//     - done_o and ack_o=0001 at t+9; model product 13*1011b correct.
//  3. mplier=0000 -> no ad_o, done at t+6. mplier=1111 -> 4 ad_o, done at t+10.
//  4. req_i=1111 held -> acks occur in order 0001, 0010, 0100, 1000, 0001.
//     - Exactly one IDLE cycle between each DONE and the next LOAD.
//  5. ptr=3, req_i=0101 -> grant 0001 (wrap). req_i drops during CALC -> job completes, ack still pulses.
//  6. Random M_i/req stress -> check every cycle:
//     - load_o/ad_o/sh_o mutually exclusive; gnt_o one-hot or zero;
//     - sh_o count per job == N; ack only in DONE.

Source files
------------

// File: rtl/mult_share_sched_pkg.sv
// Shared types and width helpers for the shared shift-add multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    ADD  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Index width for a count of n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int SEL_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] idx
);

  localparam logic [SEL_W:0] NREQ_V = (SEL_W+1)'(NREQ);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;
  logic             found;

  always_comb begin
    rot   = NREQ'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = SEL_W'(k);
      end
    end
    // Undo the rotation: winner = (ptr + offset) mod NREQ.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_V) sum = sum - NREQ_V;
    idx = sum[SEL_W-1:0];
    gnt = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one shift-add multiplier datapath among NREQ requesters.
//   state | meaning
//   IDLE  | no job; arbitrate on any request
//   LOAD  | datapath loads operands and clears accumulator
//   CALC  | inspect multiplier LSB: add if 1, shift if 0
//   ADD   | shift after an add
//   DONE  | product valid; ack the granted requester
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int N     = 4,
  localparam int SEL_W = idx_w(NREQ),
  localparam int CNT_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic             M_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [NREQ-1:0]  gnt_o,
  output logic             load_o,
  output logic             ad_o,
  output logic             sh_o,
  output logic             done_o,
  output logic [NREQ-1:0]  ack_o,
  output logic             busy_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             last_step;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign last_step = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          sel_d   = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = CALC;
      CALC: begin
        if (M_i) begin
          state_d = ADD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) state_d = DONE;
        end
      end
      ADD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last_step ? DONE : CALC;
      end
      DONE: begin
        // Next search starts just past the requester that was served.
        ptr_d   = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // Datapath controls decode the current state; M_i only matters in CALC.
  assign load_o = (state_q == LOAD);
  assign ad_o   = (state_q == CALC) && M_i;
  assign sh_o   = ((state_q == CALC) && !M_i) || (state_q == ADD);
  assign done_o = (state_q == DONE);
  assign ack_o  = (state_q == DONE) ? gnt_q : '0;
  assign busy_o = (state_q != IDLE);
  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: datapath model, schedule-expansion reference model, directed and random stimulus.
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int N    = 4;
  localparam int SW   = 2;

  typedef struct packed {
    logic            load;
    logic            ad;
    logic            sh;
    logic            done;
    logic            busy;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic [SW-1:0]   sel;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_i = '0;
  logic            m_i;
  logic [SW-1:0]   sel_o;
  logic [NREQ-1:0] gnt_o, ack_o;
  logic            load_o, ad_o, sh_o, done_o, busy_o;

  mult_share_sched #(.NREQ(NREQ), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .M_i(m_i),
    .sel_o(sel_o), .gnt_o(gnt_o), .load_o(load_o), .ad_o(ad_o), .sh_o(sh_o),
    .done_o(done_o), .ack_o(ack_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Operand registers of each requester and the external datapath model.
  logic [N-1:0] op_a [NREQ];
  logic [N-1:0] op_b [NREQ];
  logic [N-1:0] mreg = '0;
  logic [N-1:0] areg = '0;
  int nsh = 0;
  int prod = 0;
  logic p_load = 1'b0, p_ad = 1'b0, p_sh = 1'b0;
  logic [SW-1:0] p_sel = '0;
  assign m_i = mreg[0];

  always @(posedge clk) begin
    #1;
    if (p_load) begin
      mreg = op_b[p_sel];
      areg = op_a[p_sel];
      prod = 0;
      nsh  = 0;
    end else begin
      if (p_ad) prod = prod + (int'(areg) << nsh);
      if (p_sh) begin
        mreg = mreg >> 1;
        nsh++;
      end
    end
  end

  // Reference model: each granted job expands into its whole cycle schedule.
  ev_t cur = '0;
  ev_t mq[$];
  int  ptr_m = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete();
      ptr_m = 0;
      cur = '0;
    end else if (!cur.busy && req_i != '0) begin
      int w;
      ev_t e;
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_i[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
      e = '0;
      e.busy = 1'b1;
      e.gnt = NREQ'(1) << w;
      e.sel = SW'(w);
      e.load = 1'b1; mq.push_back(e); e.load = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (op_b[w][j]) begin e.ad = 1'b1; mq.push_back(e); e.ad = 1'b0; end
        e.sh = 1'b1; mq.push_back(e); e.sh = 1'b0;
      end
      e.done = 1'b1; e.ack = e.gnt; mq.push_back(e);
      ptr_m = (w + 1) % NREQ;
      cur = mq.pop_front();
    end else if (mq.size() > 0) begin
      cur = mq.pop_front();
    end else begin
      cur = '0;
    end
  end

  // Compare and event monitor, away from the active edge.
  int load_cnt = 0, done_cnt = 0, ack_cnt = 0;
  int load_cyc = 0, done_cyc = 0, gap = 0;
  int ad_cnt = 0, sh_cnt = 0, last_prod = 0;
  bit seen_done = 1'b0;
  logic [NREQ-1:0] ack_seen = '0, ack_last = '0, last_gnt = '0;

  always @(negedge clk) begin
    ev_t dv, ex;
    p_load = load_o; p_ad = ad_o; p_sh = sh_o; p_sel = sel_o;
    ack_seen = ack_o;
    if (chk_en) begin
      dv = '0;
      dv.load = load_o; dv.ad = ad_o; dv.sh = sh_o; dv.done = done_o;
      dv.busy = busy_o; dv.gnt = gnt_o; dv.ack = ack_o;
      dv.sel = cur.busy ? sel_o : '0;
      ex = cur;
      if (!cur.busy) ex.sel = '0;
      chk("cycle", 32'(dv), 32'(ex));
      chk("ctl_excl", 32'((int'(load_o) + int'(ad_o) + int'(sh_o)) <= 1), 32'd1);
      chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
      chk("ack_only_done", 32'((ack_o == '0) || done_o), 32'd1);
      if (load_o) begin
        load_cnt++;
        if (seen_done) gap = cyc - done_cyc;
        load_cyc = cyc;
        ad_cnt = 0;
        sh_cnt = 0;
        last_gnt = gnt_o;
      end
      if (ad_o) ad_cnt++;
      if (sh_o) sh_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        seen_done = 1'b1;
        last_prod = prod;
        chk("sh_per_job", 32'(sh_cnt), 32'(N));
        chk("product", 32'(prod), 32'(int'(op_a[sel_o]) * int'(op_b[sel_o])));
      end
      if (ack_o != '0) begin
        ack_cnt++;
        ack_last = ack_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
    if (done_cnt == start) chk("done_timeout", 32'(done_cnt), 32'(start + 1));
    #2;
  endtask

  task automatic wait_load(input int budget);
    int start;
    start = load_cnt;
    for (int i = 0; i < budget && load_cnt == start; i++) @(posedge clk);
    if (load_cnt == start) chk("load_timeout", 32'(load_cnt), 32'(start + 1));
    #2;
  endtask

  // Issue a request in an IDLE cycle and check timing, pulse counts and ack.
  task automatic run_job(input logic [NREQ-1:0] req, input int exp_delta,
                         input int exp_ad, input logic [NREQ-1:0] exp_ack);
    int t;
    req_i = req;
    t = cyc;
    wait_done(40);
    chk("load_latency", 32'(load_cyc - t), 32'd1);
    chk("done_latency", 32'(done_cyc - t), 32'(exp_delta));
    chk("ad_count", 32'(ad_cnt), 32'(exp_ad));
    chk("sh_count", 32'(sh_cnt), 32'(N));
    chk("ack_value", 32'(ack_last), 32'(exp_ack));
    req_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int acks_before;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;

    // 1: quiet after reset, then abort a job mid-calculation.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_outs", 32'({load_o, ad_o, sh_o, done_o, gnt_o, ack_o, sel_o}), 32'd0);
    end
    tick();
    op_a[0] = 4'd7; op_b[0] = 4'b1111;
    req_i = 4'b0001;
    wait_load(10);
    tick();
    @(negedge clk);
    chk("busy_mid_job", 32'(busy_o), 32'd1);
    tick();
    acks_before = ack_cnt;
    rst_n = 1'b0;
    req_i = '0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(busy_o), 32'd0);
    chk("abort_gnt", 32'(gnt_o), 32'd0);
    repeat (6) tick();
    chk("abort_no_ack", 32'(ack_cnt), 32'(acks_before));

    // 2: 13 x 1011b: three adds, four shifts, done at t+9.
    op_a[0] = 4'd13; op_b[0] = 4'b1011;
    run_job(4'b0001, 9, 3, 4'b0001);
    chk("product_13x11", 32'(last_prod), 32'd143);

    // 3: multiplier extremes.
    op_a[0] = 4'd5; op_b[0] = 4'b0000;
    run_job(4'b0001, 6, 0, 4'b0001);
    chk("product_5x0", 32'(last_prod), 32'd0);
    op_a[0] = 4'd15; op_b[0] = 4'b1111;
    run_job(4'b0001, 10, 4, 4'b0001);
    chk("product_15x15", 32'(last_prod), 32'd225);

    // 4: all requesting, round-robin from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    op_a[0] = 4'd3;  op_b[0] = 4'b0101;
    op_a[1] = 4'd9;  op_b[1] = 4'b0011;
    op_a[2] = 4'd12; op_b[2] = 4'b1000;
    op_a[3] = 4'd6;  op_b[3] = 4'b0110;
    req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(40);
      chk("rr_order", 32'(ack_last), 32'(4'b0001 << (n % 4)));
      if (n > 0) chk("idle_gap", 32'(gap), 32'd2);
    end
    req_i = '0;

    // 5: pointer wrap and a request dropped mid-job.
    op_a[2] = 4'd3; op_b[2] = 4'b0010;
    run_job(4'b0100, 7, 1, 4'b0100);
    begin
      int t;
      op_a[0] = 4'd9; op_b[0] = 4'b0110;
      req_i = 4'b0101;
      t = cyc;
      wait_load(10);
      chk("wrap_gnt", 32'(last_gnt), 32'b0001);
      tick();
      req_i = '0;
      wait_done(40);
      chk("drop_ack", 32'(ack_last), 32'b0001);
      chk("drop_latency", 32'(done_cyc - t), 32'd8);
      chk("drop_product", 32'(last_prod), 32'd54);
    end
    repeat (3) tick();

    // 6: random requests and operands; model and invariants check each cycle.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i]) begin
          req_i[i] = 1'b0;
        end else if (!req_i[i] && $urandom_range(0, 3) == 0) begin
          op_a[i] = N'($urandom_range(0, 15));
          op_b[i] = N'($urandom_range(0, 15));
          req_i[i] = 1'b1;
        end
      end
      tick();
    end
    req_i = '0;
    for (int i = 0; i < 40 && busy_o; i++) tick();
    chk("drain_idle", 32'(busy_o), 32'd0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
